// File: rtl/change_return_engine_pkg.sv
// Shared constants, coin values and FSM encoding for the change return engine.
package change_return_engine_pkg;

  localparam int unsigned kNumCoins  = 3;
  localparam int unsigned kTotalBits = 31;
  localparam int unsigned kStockBits = 8;

  localparam logic [kTotalBits-1:0] kCoinVal0 = 31'd100;
  localparam logic [kTotalBits-1:0] kCoinVal1 = 31'd500;
  localparam logic [kTotalBits-1:0] kCoinVal2 = 31'd1000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  function automatic logic [kTotalBits-1:0] coin_value(input int unsigned idx);
    case (idx)
      0:       coin_value = kCoinVal0;
      1:       coin_value = kCoinVal1;
      default: coin_value = kCoinVal2;
    endcase
  endfunction

endpackage

// File: rtl/change_return_engine_if.sv
// Request / coin-chute / status bundle between the vending top level and the engine.
interface change_return_engine_if;
  import change_return_engine_pkg::*;

  logic                  i_start;
  logic [kTotalBits-1:0] i_amount;
  logic                  i_ready;
  logic                  i_refill;
  logic [kNumCoins-1:0]  o_return_coin;
  logic                  o_coin_valid;
  logic                  o_busy;
  logic                  o_done;
  logic [kTotalBits-1:0] o_remainder;
  logic [kNumCoins-1:0]  o_coin_empty;

  modport master (
    output i_start, i_amount, i_ready, i_refill,
    input  o_return_coin, o_coin_valid, o_busy, o_done, o_remainder, o_coin_empty
  );

  modport slave (
    input  i_start, i_amount, i_ready, i_refill,
    output o_return_coin, o_coin_valid, o_busy, o_done, o_remainder, o_coin_empty
  );
endinterface

// File: rtl/change_return_engine_coin_select.sv
// Combinational priority picker: largest stocked denomination not exceeding remaining.
module change_return_engine_coin_select
  import change_return_engine_pkg::*;
(
  input  logic [kTotalBits-1:0] remaining,
  input  logic [kNumCoins-1:0]  avail,
  output logic [kNumCoins-1:0]  coin_onehot,
  output logic                  found,
  output logic [kTotalBits-1:0] value
);

  // Ascending scan so the highest qualifying index wins.
  always_comb begin
    coin_onehot = '0;
    found       = 1'b0;
    value       = '0;
    for (int unsigned k = 0; k < kNumCoins; k++) begin
      if (avail[k] && (coin_value(k) <= remaining)) begin
        coin_onehot    = '0;
        coin_onehot[k] = 1'b1;
        found          = 1'b1;
        value          = coin_value(k);
      end
    end
  end

endmodule

// File: rtl/change_return_engine.sv
// Change return engine: latches a balance and dispenses coins largest-first, one per handshake.
// Build option: COIN_INVENTORY_EN adds per-denomination stock counters with refill.
module change_return_engine
  import change_return_engine_pkg::*;
#(
  parameter logic [kStockBits-1:0] INIT_COUNT = 8'd20
) (
  input logic                    clk,
  input logic                    reset,
  change_return_engine_if.slave  bus
);

  state_e                state_q, state_d;
  logic [kTotalBits-1:0] remaining_q, remaining_d;
  logic [kTotalBits-1:0] remainder_q, remainder_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [kNumCoins-1:0]  avail;
  logic [kNumCoins-1:0]  sel_onehot;
  logic                  sel_found;
  logic [kTotalBits-1:0] sel_value;

`ifdef COIN_INVENTORY_EN
  logic [kStockBits-1:0] stock_q [kNumCoins];
  logic [kStockBits-1:0] stock_d [kNumCoins];

  always_comb begin
    for (int unsigned k = 0; k < kNumCoins; k++) begin
      avail[k]            = (stock_q[k] != '0);
      bus.o_coin_empty[k] = (stock_q[k] == '0);
    end
  end
`else
  logic                  unused_refill;
  localparam logic [kStockBits-1:0] unused_init_count = INIT_COUNT;

  assign unused_refill    = bus.i_refill;
  assign avail            = '1;
  assign bus.o_coin_empty = '0;
`endif

  change_return_engine_coin_select u_coin_select (
    .remaining   (remaining_q),
    .avail       (avail),
    .coin_onehot (sel_onehot),
    .found       (sel_found),
    .value       (sel_value)
  );

  // Next-state, datapath and stock updates.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    remainder_d = remainder_q;
`ifdef COIN_INVENTORY_EN
    stock_d     = stock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          remaining_d = bus.i_amount;
          remainder_d = '0;
          state_d     = ST_DISPENSE;
        end
`ifdef COIN_INVENTORY_EN
        if (bus.i_refill) begin
          for (int unsigned k = 0; k < kNumCoins; k++) stock_d[k] = INIT_COUNT;
        end
`endif
      end
      ST_DISPENSE: begin
        if (sel_found) begin
          if (bus.i_ready) begin
            remaining_d = remaining_q - sel_value;
`ifdef COIN_INVENTORY_EN
            for (int unsigned k = 0; k < kNumCoins; k++) begin
              if (sel_onehot[k]) stock_d[k] = stock_q[k] - kStockBits'(1);
            end
`endif
          end
        end else begin
          remainder_d = remaining_q;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef COIN_INVENTORY_EN
      for (int unsigned k = 0; k < kNumCoins; k++) stock_q[k] <= INIT_COUNT;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef COIN_INVENTORY_EN
      stock_q     <= stock_d;
`endif
    end
  end

  // Coin presentation decodes registered state only; i_ready never reaches it.
  assign bus.o_coin_valid  = (state_q == ST_DISPENSE) && sel_found;
  assign bus.o_return_coin = bus.o_coin_valid ? sel_onehot : '0;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_remainder   = remainder_q;

endmodule

// File: tb/tb_change_return_engine.sv
// Self-checking bench for change_return_engine: vector table plus coin scoreboard.
module tb_change_return_engine;

  typedef struct {
    logic [30:0] amount;
    int          stall_lo;
    int          stall_hi;
    int          busy_start;
    int          refill_cyc;
    int          exp_coins;
    logic [30:0] exp_rem;
    int          exp_done;
  } vec_t;

  localparam int unsigned kVal [3] = '{100, 500, 1000};

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   acc_cnt  = 0;
  int   done_cnt = 0;
  logic [30:0] exp_rem = '0;
  logic [2:0]  sb_q [$];
  int   mstock [3];

  change_return_engine_if bus ();

`ifdef COIN_INVENTORY_EN
  change_return_engine #(.INIT_COUNT(8'd1)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
`else
  change_return_engine dut (.clk(clk), .reset(reset), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Greedy reference with bench-side stock tracking.
  task automatic push_model(input logic [30:0] amt);
    logic [30:0] r;
    int k;
    r = amt;
    forever begin
      k = -1;
      for (int i = 2; i >= 0; i--) begin
        if (k < 0 && mstock[i] > 0 && 31'(kVal[i]) <= r) k = i;
      end
      if (k < 0) break;
      sb_q.push_back(3'(1 << k));
      r = r - 31'(kVal[k]);
      mstock[k]--;
    end
  endtask

  // Scoreboard: compare every presented coin and every completion.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.o_coin_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_coin: got %0h expected none at %0t", bus.o_return_coin, $time);
        end else begin
          chk("coin", 64'(bus.o_return_coin), 64'(sb_q[0]));
          if (bus.i_ready) begin
            void'(sb_q.pop_front());
            acc_cnt++;
          end
        end
      end else begin
        chk("coin_idle_zero", 64'(bus.o_return_coin), 64'd0);
      end
      if (bus.o_done) begin
        done_cnt++;
        chk("remainder", 64'(bus.o_remainder), 64'(exp_rem));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int done_at;
    int acc0;
    @(posedge clk); #1;
    exp_rem = v.exp_rem;
    push_model(v.amount);
    bus.i_start  = 1'b1;
    bus.i_amount = v.amount;
    @(posedge clk); #1;
    bus.i_start  = 1'b0;
    bus.i_amount = '1;
    acc0    = acc_cnt;
    done_at = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      bus.i_ready  = !(v.stall_lo > 0 && cyc >= v.stall_lo && cyc <= v.stall_hi);
      bus.i_start  = (cyc == v.busy_start);
      bus.i_amount = (cyc == v.busy_start) ? 31'd500 : '1;
      bus.i_refill = (cyc == v.refill_cyc);
      @(negedge clk);
      if (cyc == 1) begin
        chk("busy_cycle1", 64'(bus.o_busy), 64'd1);
        chk("remainder_cleared", 64'(bus.o_remainder), 64'd0);
      end
      if (bus.o_done) begin
        done_at = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk("done_cycle", 64'(done_at), 64'(v.exp_done));
    chk("coins_accepted", 64'(acc_cnt - acc0), 64'(v.exp_coins));
    chk("queue_drained", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
    bus.i_start  = 1'b0;
    bus.i_ready  = 1'b1;
    bus.i_refill = 1'b0;
    @(negedge clk);
    chk("idle_not_busy", 64'(bus.o_busy), 64'd0);
    chk("remainder_held", 64'(bus.o_remainder), 64'(v.exp_rem));
    sb_q.delete();
  endtask

  task automatic reset_abort_test();
    int d0;
    @(posedge clk); #1;
    exp_rem = '0;
    push_model(31'd3000);
    bus.i_start  = 1'b1;
    bus.i_amount = 31'd3000;
    bus.i_ready  = 1'b1;
    @(posedge clk); #1;           // cycle 1: first 1000 accepted
    bus.i_start = 1'b0;
    @(posedge clk); #1;           // cycle 2: reset asserted
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    chk("rst_coin_valid", 64'(bus.o_coin_valid), 64'd0);
    chk("rst_return_coin", 64'(bus.o_return_coin), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_done", 64'(bus.o_done), 64'd0);
    chk("rst_remainder", 64'(bus.o_remainder), 64'd0);
    repeat (10) @(negedge clk);
    chk("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
  endtask

  initial begin
    vec_t vecs [9];
    //            amount  slo shi bsy ref coins rem done
    vecs[0] = '{31'd1700, 0, 0, 3, 0, 4, 31'd0,  6};
    vecs[1] = '{31'd650,  2, 3, 0, 0, 2, 31'd50, 6};
    vecs[2] = '{31'd0,    0, 0, 1, 0, 0, 31'd0,  2};
    vecs[3] = '{31'd3000, 0, 0, 0, 2, 3, 31'd0,  5};
    vecs[4] = '{31'd850,  0, 0, 0, 0, 4, 31'd50, 6};
    vecs[5] = '{31'd99,   0, 0, 0, 0, 0, 31'd99, 2};
    vecs[6] = '{31'd100,  0, 0, 0, 0, 1, 31'd0,  3};
    vecs[7] = '{31'd1999, 0, 0, 0, 0, 6, 31'd99, 8};
    vecs[8] = '{31'd1999, 1, 2, 0, 0, 6, 31'd99, 10};

    reset        = 1'b1;
    bus.i_start  = 1'b0;
    bus.i_amount = '0;
    bus.i_ready  = 1'b1;
    bus.i_refill = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_valid", 64'(bus.o_coin_valid), 64'd0);
    chk("reset_coin", 64'(bus.o_return_coin), 64'd0);
    chk("reset_busy", 64'(bus.o_busy), 64'd0);
    chk("reset_done", 64'(bus.o_done), 64'd0);
    chk("reset_remainder", 64'(bus.o_remainder), 64'd0);
    chk("reset_empty", 64'(bus.o_coin_empty), 64'd0);

`ifdef COIN_INVENTORY_EN
    for (int i = 0; i < 3; i++) mstock[i] = 1;
    // 2000 with one of each: 1000, 500, 100 then stuck at 400; refill mid-run ignored
    run_vec('{31'd2000, 0, 0, 0, 1, 3, 31'd400, 5});
    chk("empty_after_depletion", 64'(bus.o_coin_empty), 64'd7);
    @(posedge clk); #1 bus.i_refill = 1'b1;
    @(posedge clk); #1 bus.i_refill = 1'b0;
    @(negedge clk);
    chk("empty_after_refill", 64'(bus.o_coin_empty), 64'd0);
    for (int i = 0; i < 3; i++) mstock[i] = 1;
    run_vec('{31'd650, 0, 0, 0, 0, 2, 31'd50, 4});
    chk("empty_partial", 64'(bus.o_coin_empty), 64'd3);
`else
    for (int i = 0; i < 3; i++) mstock[i] = 100000;
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    chk("empty_tied_low", 64'(bus.o_coin_empty), 64'd0);
`endif

    for (int i = 0; i < 3; i++) mstock[i] = 100000;
    reset_abort_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
